// File: rtl/dfs_drp_sequencer.sv
// DFS reprogramming sequencer: walks a block of configuration ROM words and issues one DRP write per word.
// It holds the MMCM in reset while writing, then releases it and waits for a synchronised LOCKED.
module dfs_drp_sequencer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 36,
  parameter int WORDS_LOG2   = 4,
  parameter int IDX_WIDTH    = 6,
  parameter int DRP_TIMEOUT  = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid_i,
  input  logic [IDX_WIDTH-1:0]  req_idx_i,
  output logic                  req_ready_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_en_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [6:0]            drp_daddr_o,
  output logic [15:0]           drp_di_o,
  output logic                  drp_den_o,
  output logic                  drp_dwe_o,
  input  logic                  drp_drdy_i,
  output logic                  mmcm_rst_o,
  input  logic                  mmcm_locked_i,
  output logic [IDX_WIDTH-1:0]  cur_idx_o,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_RD, S_RWAIT, S_WR, S_DWAIT, S_RELEASE, S_LOCK, S_DONE
  } state_t;

  localparam logic [15:0] DRP_LIM  = 16'(DRP_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LIM = 16'(LOCK_TIMEOUT - 1);
  localparam logic [WORDS_LOG2-1:0] WORD_MAX = '1;

  state_t                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [WORDS_LOG2-1:0]   word_cnt_q, word_cnt_d;
  logic [15:0]             timer_q, timer_d;
  logic                    last_q, last_d;
  logic                    lock_meta_q, lock_sync_q;
  logic                    req_ready_q, req_ready_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic                    rom_en_q, rom_en_d;
  logic [6:0]              daddr_q, daddr_d;
  logic [15:0]             di_q, di_d;
  logic                    den_q, den_d;
  logic                    mmcm_rst_q, mmcm_rst_d;
  logic [IDX_WIDTH-1:0]    cur_idx_q, cur_idx_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    unused_rom_bits;

  // Bits between the DRP address field and the terminator flag carry no meaning here.
  assign unused_rom_bits = ^rom_data_i[DATA_WIDTH-2:23];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_cnt_d = word_cnt_q;
    last_d     = last_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    cur_idx_d  = cur_idx_q;
    error_d    = error_q;
    timer_d    = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          idx_d      = req_idx_i;
          error_d    = 1'b0;
          word_cnt_d = '0;
          state_d    = (req_idx_i == cur_idx_q && !error_q) ? S_DONE : S_HOLD;
        end
      end
      S_HOLD:  state_d = S_RD;
      S_RD:    state_d = S_RWAIT;
      S_RWAIT: begin
        last_d  = rom_data_i[DATA_WIDTH-1];
        daddr_d = rom_data_i[22:16];
        di_d    = rom_data_i[15:0];
        state_d = S_WR;
      end
      S_WR:    state_d = S_DWAIT;
      S_DWAIT: begin
        if (drp_drdy_i) begin
          if (last_q) begin
            state_d = S_RELEASE;
          end else if (word_cnt_q == WORD_MAX) begin
            error_d = 1'b1;
            state_d = S_RELEASE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = S_RD;
          end
        end else if (timer_q >= DRP_LIM) begin
          error_d = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = error_q ? S_DONE : S_LOCK;
      S_LOCK: begin
        if (lock_sync_q) begin
          cur_idx_d = idx_q;
          state_d   = S_DONE;
        end else if (timer_q >= LOCK_LIM) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;

    // Outputs are decoded from the next state so they line up with the state register.
    req_ready_d = (state_d == S_IDLE);
    rom_en_d    = (state_d == S_RD);
    rom_addr_d  = (state_d == S_RD) ? {idx_d, word_cnt_d} : rom_addr_q;
    den_d       = (state_d == S_WR);
    mmcm_rst_d  = (state_d == S_HOLD) || (state_d == S_RD) || (state_d == S_RWAIT) ||
                  (state_d == S_WR) || (state_d == S_DWAIT);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      word_cnt_q  <= '0;
      timer_q     <= '0;
      last_q      <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      req_ready_q <= 1'b1;
      rom_addr_q  <= '0;
      rom_en_q    <= 1'b0;
      daddr_q     <= '0;
      di_q        <= '0;
      den_q       <= 1'b0;
      mmcm_rst_q  <= 1'b0;
      cur_idx_q   <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_cnt_q  <= word_cnt_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      lock_meta_q <= mmcm_locked_i;
      lock_sync_q <= lock_meta_q;
      req_ready_q <= req_ready_d;
      rom_addr_q  <= rom_addr_d;
      rom_en_q    <= rom_en_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      den_q       <= den_d;
      mmcm_rst_q  <= mmcm_rst_d;
      cur_idx_q   <= cur_idx_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rom_addr_o  = rom_addr_q;
  assign rom_en_o    = rom_en_q;
  assign drp_daddr_o = daddr_q;
  assign drp_di_o    = di_q;
  assign drp_den_o   = den_q;
  assign drp_dwe_o   = den_q;
  assign mmcm_rst_o  = mmcm_rst_q;
  assign cur_idx_o   = cur_idx_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule
